serial_to_parallel_rx: RTL and testbench

//  Downstream receiver for the 64-bit serializer in the board-state transfer path.

---
 rtl/conway_serial_pkg.sv | 24 ++
 rtl/word_holding_reg.sv | 37 +++
 rtl/serial_to_parallel_rx.sv | 136 +++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_serial_pkg.sv
// +----------------------------------------------------------------------------+
// | conway_serial_pkg : shared types and helpers for the board-state serial path |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package conway_serial_pkg;

    localparam int DEFAULT_WORD_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    // Counter width able to hold the value n itself (needed when the parity slot follows the last data bit).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_holding_reg.sv
// +----------------------------------------------------------------------------+
// | word_holding_reg : one-deep valid/ready output register for received words   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_holding_reg #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             accept,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             can_load
);

    // A word may be written when the slot is empty or is being drained on this edge.
    assign can_load = !valid || accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && accept) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel_rx.sv
// +----------------------------------------------------------------------------+
// | serial_to_parallel_rx : MSB-first serial word receiver with valid/ready out  |
// | Optional even-parity slot after each word: S2P_PARITY_CHECK_EN               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_to_parallel_rx
    import conway_serial_pkg::*;
#(
    parameter int data_size = DEFAULT_WORD_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SERIAL_IN,
    input  logic                 BIT_VALID,
    input  logic                 FRAME_START,
    output logic [data_size-1:0] WORD_OUT,
    output logic                 WORD_VALID,
    input  logic                 WORD_READY,
    output logic                 OVERFLOW,
    output logic                 FRAME_ERR
`ifdef S2P_PARITY_CHECK_EN
    ,
    output logic                 PARITY_ERR
`endif
);

    localparam int            CW       = cnt_width(data_size);
    localparam logic [CW-1:0] LAST_CNT = CW'(data_size - 1);

    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [data_size-1:0] r_shift;

    logic [data_size-1:0] w_shifted;
    logic [data_size-1:0] w_commit_word;
    logic                 w_commit;
    logic                 w_load;
    logic                 w_can_load;

    assign w_shifted = {r_shift[data_size-2:0], SERIAL_IN};

`ifdef S2P_PARITY_CHECK_EN
    logic w_parity_ok;
    logic w_parity_bit;

    // Even parity over the completed word plus the received parity bit.
    assign w_parity_ok   = ~^{r_shift, SERIAL_IN};
    assign w_parity_bit  = BIT_VALID && !FRAME_START && (r_state == PARITY);
    assign w_commit      = w_parity_bit && w_parity_ok;
    assign w_commit_word = r_shift;
`else
    assign w_commit      = BIT_VALID && !FRAME_START && (r_state == RECV) && (r_cnt == LAST_CNT);
    assign w_commit_word = w_shifted;
`endif

    assign w_load = w_commit && w_can_load;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef S2P_PARITY_CHECK_EN
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            if (w_commit && !w_can_load) begin
                OVERFLOW <= 1'b1;
            end
            if (BIT_VALID) begin
                if (FRAME_START) begin
                    // A start bit always opens a fresh word; outside IDLE the partial word is lost.
                    if (r_state != IDLE) begin
                        FRAME_ERR <= 1'b1;
                    end
                    r_shift <= {{(data_size-1){1'b0}}, SERIAL_IN};
                    r_cnt   <= CW'(1);
                    r_state <= RECV;
                end else begin
                    case (r_state)
                        IDLE: begin
                            r_state <= IDLE;
                        end
                        RECV: begin
                            r_shift <= w_shifted;
                            if (r_cnt == LAST_CNT) begin
`ifdef S2P_PARITY_CHECK_EN
                                r_cnt   <= r_cnt + CW'(1);
                                r_state <= PARITY;
`else
                                r_cnt   <= '0;
                                r_state <= IDLE;
`endif
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
`ifdef S2P_PARITY_CHECK_EN
                        PARITY: begin
                            if (!w_parity_ok) begin
                                PARITY_ERR <= 1'b1;
                            end
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
`endif
                        default: begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    word_holding_reg #(
        .WIDTH (data_size)
    ) u_hold (
        .CLK       (CLK),
        .RST       (RST),
        .load      (w_load),
        .load_data (w_commit_word),
        .accept    (WORD_READY),
        .data      (WORD_OUT),
        .valid     (WORD_VALID),
        .can_load  (w_can_load)
    );

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel_rx.sv
// +----------------------------------------------------------------------------+
// | tb_serial_to_parallel_rx : randomized self-checking bench, 8-bit words       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_to_parallel_rx;

    localparam int W = 8;
`ifdef S2P_PARITY_CHECK_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         SERIAL_IN;
    logic         BIT_VALID;
    logic         FRAME_START;
    logic [W-1:0] WORD_OUT;
    logic         WORD_VALID;
    logic         WORD_READY;
    logic         OVERFLOW;
    logic         FRAME_ERR;
`ifdef S2P_PARITY_CHECK_EN
    logic         PARITY_ERR;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits of the current frame collected in a queue, plus the output slot.
    bit           q[$];
    bit           in_frame;
    logic [W-1:0] m_word;
    bit           m_valid, m_ovf, m_ferr, m_perr;

    always #5 CLK = ~CLK;

    serial_to_parallel_rx #(
        .data_size (W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SERIAL_IN   (SERIAL_IN),
        .BIT_VALID   (BIT_VALID),
        .FRAME_START (FRAME_START),
        .WORD_OUT    (WORD_OUT),
        .WORD_VALID  (WORD_VALID),
        .WORD_READY  (WORD_READY),
        .OVERFLOW    (OVERFLOW),
        .FRAME_ERR   (FRAME_ERR)
`ifdef S2P_PARITY_CHECK_EN
        ,
        .PARITY_ERR  (PARITY_ERR)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_frame = 1'b0;
        m_word   = '0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        m_ferr   = 1'b0;
        m_perr   = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit bv, input bit fs, input bit rdy);
        bit           commit = 1'b0;
        bit           par;
        logic [W-1:0] cw = '0;
        if (bv) begin
            if (fs) begin
                if (in_frame) m_ferr = 1'b1;
                q.delete();
                q.push_back(s);
                in_frame = 1'b1;
            end else if (in_frame) begin
                q.push_back(s);
            end
            if (in_frame && q.size() == FRAME_LEN) begin
                for (int i = 0; i < W; i++) cw = {cw[W-2:0], q[i]};
                par = 1'b0;
                foreach (q[i]) par ^= q[i];
`ifdef S2P_PARITY_CHECK_EN
                if (par == 1'b0) commit = 1'b1;
                else m_perr = 1'b1;
`else
                commit = 1'b1;
`endif
                q.delete();
                in_frame = 1'b0;
            end
        end
        if (commit) begin
            if (!m_valid || rdy) begin
                m_word  = cw;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("word_valid", WORD_VALID, m_valid);
        check("word_out", WORD_OUT, m_word);
        check("overflow", OVERFLOW, m_ovf);
        check("frame_err", FRAME_ERR, m_ferr);
`ifdef S2P_PARITY_CHECK_EN
        check("parity_err", PARITY_ERR, m_perr);
`endif
    endtask

    task automatic cycle(input bit s, input bit bv, input bit fs, input bit rdy);
        SERIAL_IN   = s;
        BIT_VALID   = bv;
        FRAME_START = fs;
        WORD_READY  = rdy;
        model_step(s, bv, fs, rdy);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit gaps, input bit flip);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(w[i], 1'b1, (i == W - 1), rdy);
            if (gaps) cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), rdy);
        end
`ifdef S2P_PARITY_CHECK_EN
        cycle((^w) ^ flip, 1'b1, 1'b0, rdy);
`else
        if (flip) cycle(1'b0, 1'b0, 1'b0, rdy);
`endif
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_word_out", WORD_OUT, 0);
        check("rst_word_valid", WORD_VALID, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_frame_err", FRAME_ERR, 0);
`ifdef S2P_PARITY_CHECK_EN
        check("rst_parity_err", PARITY_ERR, 0);
`endif
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_outputs();
    endtask

    initial begin
        RST         = 1'b1;
        SERIAL_IN   = 1'b0;
        BIT_VALID   = 1'b0;
        FRAME_START = 1'b0;
        WORD_READY  = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        RST = 1'b0;

        // Plain word, consumer always ready: valid for exactly one cycle.
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        check("t1_word", WORD_OUT, 8'hA5);
        check("t1_valid_rise", WORD_VALID, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_fall", WORD_VALID, 0);

        // Gapped bits with junk on idle cycles.
        send_word(8'h3C, 1'b1, 1'b1, 1'b0);
        check("t2_word", WORD_OUT, 8'h3C);
        check("t2_flags", {OVERFLOW, FRAME_ERR}, 0);

        // Holding full: second word dropped.
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        check("t3_word_kept", WORD_OUT, 8'h11);
        check("t3_overflow", OVERFLOW, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_drained", WORD_VALID, 0);
        do_reset();

        // Restart mid-word.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, (i == 0), 1'b1);
        send_word(8'hF0, 1'b1, 1'b0, 1'b0);
        check("t4_frame_err", FRAME_ERR, 1);
        check("t4_word", WORD_OUT, 8'hF0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, (i == 0), 1'b1);
        do_reset();
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        check("t5_word", WORD_OUT, 8'h81);
        check("t5_flags", {OVERFLOW, FRAME_ERR}, 0);

`ifdef S2P_PARITY_CHECK_EN
        do_reset();
        send_word(8'h03, 1'b1, 1'b0, 1'b0);
        check("t6_good_valid", WORD_VALID, 1);
        check("t6_good_word", WORD_OUT, 8'h03);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h03, 1'b1, 1'b0, 1'b1);
        check("t6_bad_perr", PARITY_ERR, 1);
        check("t6_bad_valid", WORD_VALID, 0);
`endif

        // Randomized mix of whole words and free-running noise.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 25; k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    send_word(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 4) == 0));
                end else begin
                    for (int c = 0; c < 12; c++) begin
                        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
